// File: rtl/pe_result_collector.sv
// ============================================================================
// Module   : pe_result_collector
// Purpose  : Gathers one result word per PE lane per round (any order),
//            then streams them out in lane order on a valid/ready port.
//            Optional macro PE_COLLECTOR_CHKSUM_EN appends an XOR checksum word.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pe_result_collector #(
    parameter  int NUM_PE  = 8,
    parameter  int DATA_W  = 32,
    parameter  int ROUND_W = 16,
    localparam int IDX_W   = $clog2(NUM_PE + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_PE*DATA_W-1:0] result_i,
    input  logic [NUM_PE-1:0]        result_vld_i,
    input  logic                     clr_ovr_i,
    output logic                     accept_o,
    output logic [DATA_W-1:0]        out_data_o,
    output logic [IDX_W-1:0]         out_pe_o,
    output logic [ROUND_W-1:0]       out_round_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic                     round_done_o,
    output logic [NUM_PE-1:0]        overrun_o
);

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        DRAIN   = 1'b1
    } state_t;

`ifdef PE_COLLECTOR_CHKSUM_EN
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PE);
`else
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PE - 1);
`endif

    state_t               state_q, state_d;
    logic [NUM_PE-1:0]    cap_q, cap_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [ROUND_W-1:0]   round_q, round_d;
    logic [DATA_W-1:0]    bank_q [NUM_PE];
    logic [DATA_W-1:0]    bank_d [NUM_PE];
    logic [NUM_PE-1:0]    ovr_q, ovr_d;
    logic                 done_q, done_d;
`ifdef PE_COLLECTOR_CHKSUM_EN
    logic [DATA_W-1:0]    chk_q, chk_d;
`endif

    logic [DATA_W-1:0]    rd_word;
    logic [NUM_PE-1:0]    ovr_set;
    logic                 draining;
    logic                 hs;

    assign draining = (state_q == DRAIN);
    assign hs       = draining && out_ready_i;

    // Loop-based read mux keeps the pointer width independent of bank depth.
    always_comb begin
        rd_word = '0;
        for (int k = 0; k < NUM_PE; k++) begin
            if (ptr_q == IDX_W'(k)) begin
                rd_word = bank_q[k];
            end
        end
`ifdef PE_COLLECTOR_CHKSUM_EN
        if (ptr_q == IDX_W'(NUM_PE)) begin
            rd_word = chk_q;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        cap_d   = cap_q;
        ptr_d   = ptr_q;
        round_d = round_q;
        bank_d  = bank_q;
        done_d  = 1'b0;
        ovr_set = '0;
`ifdef PE_COLLECTOR_CHKSUM_EN
        chk_d   = chk_q;
`endif
        case (state_q)
            COLLECT: begin
                for (int k = 0; k < NUM_PE; k++) begin
                    if (result_vld_i[k]) begin
                        if (!cap_q[k]) begin
                            bank_d[k] = result_i[k*DATA_W +: DATA_W];
                            cap_d[k]  = 1'b1;
`ifdef PE_COLLECTOR_CHKSUM_EN
                            chk_d     = chk_d ^ result_i[k*DATA_W +: DATA_W];
`endif
                        end else begin
                            ovr_set[k] = 1'b1;
                        end
                    end
                end
                if (&cap_d) begin
                    state_d = DRAIN;
                    ptr_d   = '0;
                end
            end
            DRAIN: begin
                // Any strobe while draining belongs to no open round.
                ovr_set = result_vld_i;
                if (hs) begin
                    if (ptr_q == LAST_IDX) begin
                        done_d  = 1'b1;
                        cap_d   = '0;
                        round_d = round_q + ROUND_W'(1);
                        ptr_d   = '0;
                        state_d = COLLECT;
`ifdef PE_COLLECTOR_CHKSUM_EN
                        chk_d   = '0;
`endif
                    end else begin
                        ptr_d = ptr_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = COLLECT;
        endcase
        // A new overrun outranks a simultaneous clear.
        ovr_d = (clr_ovr_i ? '0 : ovr_q) | ovr_set;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= COLLECT;
            cap_q   <= '0;
            ptr_q   <= '0;
            round_q <= '0;
            ovr_q   <= '0;
            done_q  <= 1'b0;
            for (int k = 0; k < NUM_PE; k++) begin
                bank_q[k] <= '0;
            end
`ifdef PE_COLLECTOR_CHKSUM_EN
            chk_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cap_q   <= cap_d;
            ptr_q   <= ptr_d;
            round_q <= round_d;
            ovr_q   <= ovr_d;
            done_q  <= done_d;
            for (int k = 0; k < NUM_PE; k++) begin
                bank_q[k] <= bank_d[k];
            end
`ifdef PE_COLLECTOR_CHKSUM_EN
            chk_q   <= chk_d;
`endif
        end
    end

    assign accept_o     = (state_q == COLLECT);
    assign out_valid_o  = draining;
    assign out_data_o   = draining ? rd_word : '0;
    assign out_pe_o     = ptr_q;
    assign out_round_o  = round_q;
    assign round_done_o = done_q;
    assign overrun_o    = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_pe_result_collector.sv
// ============================================================================
// Module   : tb_pe_result_collector
// Purpose  : Directed scoreboard bench for pe_result_collector (NUM_PE=8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pe_result_collector;

    localparam int NP = 8;
    localparam int DW = 32;
    localparam int RW = 16;
    localparam int IW = 4;
`ifdef PE_COLLECTOR_CHKSUM_EN
    localparam int LAST = 8;
`else
    localparam int LAST = 7;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NP*DW-1:0]  result_i = '0;
    logic [NP-1:0]     result_vld_i = '0;
    logic              clr_ovr_i = 1'b0;
    logic              accept_o;
    logic [DW-1:0]     out_data_o;
    logic [IW-1:0]     out_pe_o;
    logic [RW-1:0]     out_round_o;
    logic              out_valid_o;
    logic              out_ready_i = 1'b1;
    logic              round_done_o;
    logic [NP-1:0]     overrun_o;

    pe_result_collector #(.NUM_PE(NP), .DATA_W(DW), .ROUND_W(RW)) dut (
        .clk          (clk),
        .reset        (reset),
        .result_i     (result_i),
        .result_vld_i (result_vld_i),
        .clr_ovr_i    (clr_ovr_i),
        .accept_o     (accept_o),
        .out_data_o   (out_data_o),
        .out_pe_o     (out_pe_o),
        .out_round_o  (out_round_o),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .round_done_o (round_done_o),
        .overrun_o    (overrun_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic [IW-1:0] pe;
        logic [RW-1:0] round;
        bit            last;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            done_cnt = 0;
    int            exp_done = 0;
    int            first_pop = 0;
    int            last_pop = -10;
    logic [DW-1:0] lane_data [NP];
    logic [DW-1:0] m_bank [NP];
    logic [NP-1:0] m_cap = '0;
    logic [NP-1:0] m_ovr = '0;
    logic [RW-1:0] exp_round = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset) begin
            if (out_valid_o && out_ready_i) begin
                if (sb.size() == 0) begin
                    check("unexpected_word", 64'd1, 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("out_data", out_data_o, mon_e.data);
                    check("out_pe", out_pe_o, mon_e.pe);
                    check("out_round", out_round_o, mon_e.round);
                    if (mon_e.pe == 0) first_pop = cyc;
                    if (mon_e.last) last_pop = cyc;
                end
            end
            if (round_done_o) begin
                done_cnt++;
                check("done_latency", cyc, last_pop + 1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_round();
        exp_t e;
        logic [DW-1:0] x;
        x = '0;
        for (int k = 0; k < NP; k++) begin
            e.data = m_bank[k]; e.pe = IW'(k); e.round = exp_round; e.last = (k == LAST);
            sb.push_back(e);
            x ^= m_bank[k];
        end
`ifdef PE_COLLECTOR_CHKSUM_EN
        e.data = x; e.pe = IW'(NP); e.round = exp_round; e.last = 1'b1;
        sb.push_back(e);
`endif
        m_cap = '0;
        exp_round++;
        exp_done++;
    endtask

    // Strobe lanes while collecting; the model mirrors first-write-wins capture.
    task automatic strobe(input logic [NP-1:0] mask);
        for (int k = 0; k < NP; k++) begin
            result_i[k*DW +: DW] = lane_data[k];
            if (mask[k]) begin
                if (m_cap[k]) m_ovr[k] = 1'b1;
                else begin
                    m_bank[k] = lane_data[k];
                    m_cap[k]  = 1'b1;
                end
            end
        end
        result_vld_i = mask;
        tick();
        result_vld_i = '0;
        if (&m_cap) push_round();
    endtask

    task automatic set_data(input logic [DW-1:0] base);
        for (int k = 0; k < NP; k++) lane_data[k] = base + DW'(k);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && done_cnt != exp_done; i++) tick();
        check("round_done_count", done_cnt, exp_done);
        check("scoreboard_empty", sb.size(), 0);
    endtask

    task automatic wait_pe(input int p);
        for (int i = 0; i < 30 && out_pe_o != IW'(p); i++) tick();
        check("reach_ptr", out_pe_o, p);
    endtask

    initial begin
        int saved;
        for (int k = 0; k < NP; k++) begin
            lane_data[k] = '0;
            m_bank[k] = '0;
        end
        tick();
        tick();
        check("rst_accept", accept_o, 1);
        check("rst_valid", out_valid_o, 0);
        check("rst_data", out_data_o, 0);
        check("rst_pe", out_pe_o, 0);
        check("rst_round", out_round_o, 0);
        check("rst_done", round_done_o, 0);
        check("rst_ovr", overrun_o, 0);
        reset = 1'b1;
        tick();

        // In-order round, one lane per cycle
        set_data(32'h100);
        for (int k = 0; k < NP - 1; k++) strobe(NP'(1) << k);
        check("valid_before_last", out_valid_o, 0);
        strobe(NP'(1) << (NP - 1));
        check("valid_after_last", out_valid_o, 1);
        check("accept_in_drain", accept_o, 0);
        wait_drain();
        check("no_bubble", last_pop - first_pop, LAST);

        // Out-of-order plus same-cycle capture
        set_data(32'h200);
        strobe(8'h88);
        strobe(8'h77);
        wait_drain();

        // Backpressure at lane 2
        set_data(32'h300);
        strobe(8'hFF);
        wait_pe(2);
        out_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_pe", out_pe_o, 2);
            check("bp_data", out_data_o, 32'h302);
            check("bp_valid", out_valid_o, 1);
        end
        out_ready_i = 1'b1;
        wait_drain();

        // Overrun: lane 4 twice in COLLECT, lane 1 during DRAIN
        set_data(32'h400);
        strobe(8'h10);
        lane_data[4] = 32'hDEAD_BEEF;
        strobe(8'h10);
        strobe(8'hEF);
        result_i[1*DW +: DW] = 32'hBAD;
        result_vld_i = 8'h02;
        m_ovr[1] = 1'b1;
        tick();
        result_vld_i = '0;
        wait_drain();
        check("overrun_flags", overrun_o, 8'h12);
        check("overrun_model", overrun_o, m_ovr);
        clr_ovr_i = 1'b1;
        tick();
        clr_ovr_i = 1'b0;
        m_ovr = '0;
        check("overrun_clear", overrun_o, 0);

        // Clear coinciding with a new overrun; data 1..8 (checksum = 8)
        for (int k = 0; k < NP; k++) lane_data[k] = DW'(k + 1);
        strobe(8'h01);
        clr_ovr_i = 1'b1;
        m_ovr = '0;
        strobe(8'h01);
        clr_ovr_i = 1'b0;
        check("overrun_beats_clear", overrun_o, 8'h01);
        strobe(8'hFE);
        wait_drain();
        clr_ovr_i = 1'b1;
        tick();
        clr_ovr_i = 1'b0;
        m_ovr = '0;

        // Reset mid-DRAIN at lane 5
        set_data(32'h600);
        strobe(8'hFF);
        wait_pe(5);
        saved = done_cnt;
        reset = 1'b0;
        #1;
        check("mid_rst_accept", accept_o, 1);
        check("mid_rst_valid", out_valid_o, 0);
        check("mid_rst_data", out_data_o, 0);
        check("mid_rst_pe", out_pe_o, 0);
        check("mid_rst_round", out_round_o, 0);
        check("mid_rst_ovr", overrun_o, 0);
        sb.delete();
        m_cap = '0;
        m_ovr = '0;
        exp_round = '0;
        exp_done = saved;
        tick();
        tick();
        reset = 1'b1;
        tick();
        tick();
        check("mid_rst_no_done", done_cnt, saved);
        check("mid_rst_done_low", round_done_o, 0);

        // Full round after reset reports round 0
        set_data(32'h700);
        strobe(8'hF0);
        strobe(8'h0F);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pe_result_collector.md
Name: pe_result_collector

Overview:
- Parametrised result-gathering stage behind the PEran array; replaces the fixed 8-lane `final_result` concatenation with a real collector.
- Captures one result word per PE lane per simulation round, in any order.
- Once every lane has reported, streams the results out in lane order on a valid/ready interface with lane index and round number.
- Flags lanes that overrun, i.e. produce a second result in the same round.

Parameters:
- NUM_PE, 8, number of PE lanes (1..64).
- DATA_W, 32, width of each PE final_result word.
- ROUND_W, 16, width of round counter.
- IDX_W, derived = clog2(NUM_PE+1), lane index width; local parameter, not overridable.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- result_i  in  NUM_PE*DATA_W  flattened PE results; lane k occupies bits [k*DATA_W +: DATA_W].
- result_vld_i  in  NUM_PE  per-lane single-cycle valid strobe.
- clr_ovr_i  in  1  synchronous clear of overrun flags.
- accept_o  out  1  high while collecting (COLLECT state).
- out_data_o  out  DATA_W  streamed result word.
- out_pe_o  out  IDX_W  lane index of out_data_o.
- out_round_o  out  ROUND_W  round number of current output.
- out_valid_o  out  1  output valid.
- out_ready_i  in  1  downstream ready.
- round_done_o  out  1  one-cycle pulse after the last word of a round is accepted.
- overrun_o  out  NUM_PE  sticky per-lane overrun flags.

Behaviour:
- Reset (reset=0, async) values:
  - State = COLLECT; captured mask = 0; lane pointer = 0; round = 0.
  - accept_o=1, out_valid_o=0, out_data_o=0, out_pe_o=0, out_round_o=0, round_done_o=0, overrun_o=0.
  - Bank contents are cleared to 0.
- COLLECT state:
  - Each cycle, for each lane k with result_vld_i[k]=1 and captured[k]=0: bank[k] <= lane k data, captured[k] <= 1.
  - If result_vld_i[k]=1 and captured[k]=1: data is dropped and overrun_o[k] <= 1.
  - Several lanes may strobe in the same cycle; all of them are captured.
  - When the mask becomes all-ones (including lanes captured this cycle), the next state is DRAIN with pointer = 0.
  - out_valid_o rises 1 cycle after the edge that captures the final lane.
- DRAIN state:
  - accept_o=0, out_valid_o=1, out_data_o=bank[ptr], out_pe_o=ptr, out_round_o=round.
  - Any result_vld_i[k] in DRAIN sets overrun_o[k] and the data is dropped.
  - Handshake occurs when out_valid_o & out_ready_i, and advances ptr.
  - Output holds stable while out_ready_i=0.
  - On handshake with ptr==NUM_PE-1:
    - round_done_o pulses for 1 cycle (the following cycle).
    - Captured mask clears and round increments, wrapping from 2^ROUND_W-1 to 0.
    - State returns to COLLECT.
  - No bubble between words when out_ready_i is held 1: sustained 1 word/cycle.
- overrun_o is cleared only by reset or clr_ovr_i=1. If clr_ovr_i and a new overrun occur in the same cycle, the new overrun wins (flag = 1).
- NUM_PE=1: DRAIN lasts 1 word; round_done follows each handshake.
- Reset asserted mid-DRAIN discards the partial round; no round_done_o pulse.

Optional Feature:
- Macro: PE_COLLECTOR_CHKSUM_EN.
- Defined:
  - After lane NUM_PE-1 is accepted, DRAIN emits one extra word: XOR of all NUM_PE bank words, with out_pe_o=NUM_PE.
  - round_done_o pulses after the checksum word is accepted instead of after lane NUM_PE-1.
  - The checksum is computed incrementally during capture, not as a final-cycle reduction.
- Undefined: no checksum word; round ends after lane NUM_PE-1. Index value NUM_PE is never output.

Test Plan:
- In-order round: NUM_PE=8, strobe lanes 0..7 on consecutive cycles with data 32'h100+k, out_ready=1.
  - Expect 8 output words 32'h100..32'h107 with out_pe 0..7 and out_round 0, on 8 consecutive cycles.
  - Expect round_done 1 cycle after the last word; then round=1.
- Out-of-order plus same-cycle capture: strobe lanes 7,3 together, then the other six lanes all together.
  - Output order is still 0..7, with correct data per lane.
- Backpressure: hold out_ready=0 for 5 cycles at ptr=2, then release.
  - out_data_o/out_pe_o stay stable at lane 2; no words are lost or duplicated.
- Overrun: strobe lane 4 twice in COLLECT, and lane 1 during DRAIN.
  - overrun_o=8'b0001_0010; the first lane-4 value is the one streamed out.
  - After clr_ovr_i pulse, overrun_o=0.
- Reset mid-DRAIN at ptr=5: all outputs return to reset values immediately (async); no round_done_o pulse.
  - The next full round is reported with out_round=0.
- Checksum build (PE_COLLECTOR_CHKSUM_EN), data 32'h1..32'h8:
  - Ninth word = 32'h8 (XOR of 1..8) with out_pe_o=8.
  - round_done_o pulses after that word is accepted.
